// File: rtl/bcd_step_sequencer.sv
// Command-driven sequencer for a DIGITS-wide BCD up/down counter cascade; one step per clock in RUN.
// LOAD/op11 done one cycle after accept, RUN done N+2 cycles after accept; cmd_ready low (stall) in RUN.
module bcd_step_sequencer #(
   parameter int DIGITS = 4,
   parameter int STEP_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [4*DIGITS-1:0]   cmd_data,
   input  logic                  abort,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy,
   output logic                  done,
   output logic                  wrap,
   output logic                  err
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [STEP_W-1:0] REM_ONE = STEP_W'(1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              r_state;
   logic [STEP_W-1:0]   r_rem;
   logic                r_dir_down;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_done;
   logic                r_wrap;
   logic                r_err;

   logic [4*DIGITS-1:0] w_bcd_up;
   logic [4*DIGITS-1:0] w_bcd_dn;
   logic                w_carry;
   logic                w_borrow;
   logic                w_load_ok;

   // Ripple carry/borrow digit by digit; a surviving carry/borrow means full-range wrap.
   always_comb begin
      w_bcd_up  = r_bcd;
      w_bcd_dn  = r_bcd;
      w_carry   = 1'b1;
      w_borrow  = 1'b1;
      w_load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_carry) begin
            if (r_bcd[4*i +: 4] == 4'd9) begin
               w_bcd_up[4*i +: 4] = 4'd0;
            end else begin
               w_bcd_up[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
               w_carry = 1'b0;
            end
         end
         if (w_borrow) begin
            if (r_bcd[4*i +: 4] == 4'd0) begin
               w_bcd_dn[4*i +: 4] = 4'd9;
            end else begin
               w_bcd_dn[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
               w_borrow = 1'b0;
            end
         end
         if (cmd_data[4*i +: 4] > 4'd9) begin
            w_load_ok = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rem      <= '0;
         r_dir_down <= 1'b0;
         r_bcd      <= '0;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_op == OP_LOAD) begin
                     // An invalid LOAD keeps err set even if it was already set.
                     if (w_load_ok) begin
                        r_bcd <= cmd_data;
                        r_err <= 1'b0;
                     end else begin
                        r_err <= 1'b1;
                     end
                     r_done <= 1'b1;
                  end else if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
                     r_rem      <= cmd_data[STEP_W-1:0];
                     r_dir_down <= (cmd_op == OP_DOWN);
                     r_err      <= 1'b0;
                     r_state    <= S_RUN;
                  end else begin
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_rem   <= '0;
                  r_state <= S_IDLE;
               end else if (r_rem == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_bcd  <= r_dir_down ? w_bcd_dn : w_bcd_up;
                  r_wrap <= r_dir_down ? w_borrow : w_carry;
                  r_rem  <= r_rem - REM_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign bcd_out   = r_bcd;
   assign done      = r_done;
   assign wrap      = r_wrap;
   assign err       = r_err;

endmodule

// File: doc/bcd_step_sequencer.md
Name: bcd_step_sequencer

Overview:
Command-driven controller that sequences a DIGITS-wide cascade of BCD up/down digit counters.
- Accepts LOAD / RUN_UP / RUN_DOWN commands over a valid/ready handshake.
- Steps the cascade one count per clock for a commanded number of steps.
- Reports completion, full-range wrap-around and command errors.
- Sits between the system control path and any multi-digit BCD display or count datapath.

Parameters:
DIGITS, 4, number of cascaded BCD digits (count range 0 to 10^DIGITS-1)
STEP_W, 16, width of the binary step-count field taken from cmd_data

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present; source holds cmd_op/cmd_data stable until accepted
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 reserved
cmd_data  input  4*DIGITS  LOAD: packed BCD value, digit 0 in [3:0]; RUN: step count N in [STEP_W-1:0], upper bits ignored
abort  input  1  level; terminates a RUN in progress
bcd_out  output  4*DIGITS  current packed BCD count
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
wrap  output  1  one-cycle pulse on full-range wrap
err  output  1  sticky command error flag

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n low) acts immediately:
  - bcd_out=0, busy=0, done=0, wrap=0, err=0, remaining-step counter=0, state=IDLE.
  - cmd_ready is 1 in the first cycle after release.
- FSM states IDLE and RUN. cmd_ready = (state==IDLE). busy = (state==RUN). Accept = cmd_valid && cmd_ready at a rising edge (edge T0).
- LOAD:
  - Accepted at T0; state stays IDLE; done=1 for the cycle after T0.
  - All nibbles <=9: bcd_out <= cmd_data at T0.
  - Any nibble >9: bcd_out unchanged, err set at T0.
- Reserved op 11: accepted, no count change, err set, done pulse as for LOAD.
- RUN_UP / RUN_DOWN:
  - At T0: rem <= N, direction latched, state <= RUN.
  - Each edge in RUN with rem>0: one step in the latched direction, rem decrements.
  - Edge in RUN with rem==0: state <= IDLE, done=1 for the following cycle.
  - Steps occur at edges T1..TN; done is high in the cycle after edge TN+1; busy is high for N+1 cycles.
  - N=0: one RUN cycle, no step, then done.
- Step arithmetic, per digit, ripple through the cascade:
  - Up: digit increments; 9->0 generates a carry into the next digit; a digit changes only when all lower digits carry.
  - Down: digit decrements; 0->9 generates a borrow, symmetric to up.
  - The whole update completes in one cycle. No binary intermediate; nibble values never leave 0..9.
- Wrap:
  - Up step from all-9s to all-0s, or down step from all-0s to all-9s.
  - wrap=1 for the cycle after that edge. Counting continues; wrap is not an error.
- err:
  - Set by an invalid LOAD or op 11.
  - Cleared at acceptance of any subsequent valid command.
  - If set and clear coincide, set wins.
- abort:
  - Sampled only in RUN. At an edge with abort=1 in RUN: no step, state <= IDLE, rem <= 0, no done pulse; bcd_out holds its last value.
  - Abort has priority over the final step and over rem==0 completion in the same cycle.
  - Ignored in IDLE.
- Output timing: done and wrap are registered; all outputs are registered except cmd_ready and busy, which decode from the state register.
- Commands presented while busy stall; cmd_ready stays low, and none are dropped or queued.
- Reset asserted mid-RUN aborts immediately with no done pulse.

Test Plan:
1. Reset then LOAD 0x0998 -> bcd_out=0x0998 after T0, done pulse 1 cycle, err=0, busy stays 0.
2. From 0x0998, RUN_UP N=3 -> bcd_out 0x0999, 0x1000, 0x1001 at T1..T3; busy 4 cycles; done after T4; wrap never set.
3. From 0x0001, RUN_DOWN N=2 -> 0x0000 then 0x9999; wrap pulses exactly once after T2; done after T3.
4. LOAD 0x12A4 -> err=1, bcd_out unchanged, done pulse. Next LOAD 0x0005 -> err=0, bcd_out=0x0005. Op 11 -> err=1, count unchanged.
5. From 0x0000, RUN_UP N=100 with abort high in the cycle after the 10th step -> bcd_out=0x0010, no done, cmd_ready=1 next cycle. A cmd_valid held during RUN is accepted only after returning to IDLE.
6. rst_n low mid-RUN at count 0x0042 -> all outputs 0 immediately. After release, cmd_ready=1 and RUN_UP N=0 produces done after 2 edges with no count change.
